// File: rtl/schmitt_filter_n_pkg.sv
// Shared definitions for the N-channel clocked Schmitt trigger.
//
// Holds the default parameter values used by both the top level and the
// per-channel filter, and the event encoding used inside a channel to
// produce the RISE/FALL pulses.  The event is a single enumerated value,
// so a channel can never report a rise and a fall in the same cycle.
package schmitt_filter_n_pkg;

  localparam int DEF_N           = 4;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_CW          = 4;
  localparam int DEF_MAXC        = 15;
  localparam int DEF_TH_HI       = 12;
  localparam int DEF_TH_LO       = 3;
  localparam bit DEF_INIT        = 1'b0;

  // Output-level event produced by one channel on one clock edge.
  typedef enum logic [1:0] {
    EV_NONE = 2'd0,
    EV_RISE = 2'd1,
    EV_FALL = 2'd2
  } edge_ev_t;

endpackage : schmitt_filter_n_pkg

// File: rtl/schmitt_filter_n_ch.sv
// One channel of the clocked Schmitt trigger.
//
// Purpose:
//   Synchronises a raw asynchronous input, integrates it in a saturating
//   up/down counter and derives a hysteresis-qualified level plus
//   single-cycle rise/fall pulses.
//
// Ports:
//   clk   in  rising-edge clock
//   rn    in  synchronous active-low reset
//   en    in  filter enable; 0 freezes counter and level (sync keeps running)
//   din   in  raw asynchronous input
//   y     out filtered level (registered)
//   rise  out 1-cycle pulse on y 0->1 (registered)
//   fall  out 1-cycle pulse on y 1->0 (registered)
module schmitt_filter_n_ch
  import schmitt_filter_n_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CW          = DEF_CW,
  parameter int MAXC        = DEF_MAXC,
  parameter int TH_HI       = DEF_TH_HI,
  parameter int TH_LO       = DEF_TH_LO,
  parameter bit INIT        = DEF_INIT
) (
  input  logic clk,
  input  logic rn,
  input  logic en,
  input  logic din,
  output logic y,
  output logic rise,
  output logic fall
);

  localparam logic [CW-1:0] MAXC_C  = CW'(MAXC);
  localparam logic [CW-1:0] TH_HI_C = CW'(TH_HI);
  localparam logic [CW-1:0] TH_LO_C = CW'(TH_LO);
  localparam logic [CW-1:0] CNT_RST = INIT ? MAXC_C : '0;

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [CW-1:0]          cnt_reg;
  logic [CW-1:0]          cnt_next;
  logic                   y_reg;
  logic                   y_next;
  logic                   rise_reg;
  logic                   fall_reg;
  edge_ev_t               ev_next;
  logic                   s;

  // Synchroniser chain: free-running, only reset touches it.
  for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
    if (gi == 0) begin : g_first
      always_ff @(posedge clk) begin
        if (!rn) sync_reg[gi] <= INIT;
        else     sync_reg[gi] <= din;
      end
    end else begin : g_rest
      always_ff @(posedge clk) begin
        if (!rn) sync_reg[gi] <= INIT;
        else     sync_reg[gi] <= sync_reg[gi-1];
      end
    end
  end

  assign s = sync_reg[SYNC_STAGES-1];

  // Saturating integrator and threshold decision.  The level decision looks
  // at the count being written this edge, so the crossing and the output
  // change land on the same clock.
  always_comb begin
    cnt_next = cnt_reg;
    y_next   = y_reg;
    ev_next  = EV_NONE;
    if (en) begin
      if (s) begin
        if (cnt_reg != MAXC_C) cnt_next = cnt_reg + 1'b1;
      end else begin
        if (cnt_reg != '0) cnt_next = cnt_reg - 1'b1;
      end

      if (!y_reg && (cnt_next >= TH_HI_C)) begin
        y_next  = 1'b1;
        ev_next = EV_RISE;
      end else if (y_reg && (cnt_next <= TH_LO_C)) begin
        y_next  = 1'b0;
        ev_next = EV_FALL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rn) begin
      cnt_reg  <= CNT_RST;
      y_reg    <= INIT;
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;
    end else begin
      cnt_reg  <= cnt_next;
      y_reg    <= y_next;
      rise_reg <= (ev_next == EV_RISE);
      fall_reg <= (ev_next == EV_FALL);
    end
  end

  assign y    = y_reg;
  assign rise = rise_reg;
  assign fall = fall_reg;

endmodule : schmitt_filter_n_ch

// File: rtl/schmitt_filter_n.sv
// N-channel clocked digital Schmitt trigger.
//
// Purpose:
//   Filters N noisy/asynchronous inputs independently: synchroniser,
//   saturating integrator, hysteresis output and rise/fall event pulses.
//   All outputs are registered.
//
// Ports:
//   CLK   in  1  rising-edge clock
//   RN    in  1  synchronous active-low reset
//   EN    in  1  filter enable; 0 freezes counters and levels
//   IN    in  N  raw inputs, bit i = channel i
//   Y     out N  filtered levels
//   RISE  out N  1-cycle pulse when Y[i] goes 0->1
//   FALL  out N  1-cycle pulse when Y[i] goes 1->0
module schmitt_filter_n
  import schmitt_filter_n_pkg::*;
#(
  parameter int N           = DEF_N,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CW          = DEF_CW,
  parameter int MAXC        = DEF_MAXC,
  parameter int TH_HI       = DEF_TH_HI,
  parameter int TH_LO       = DEF_TH_LO,
  parameter bit INIT        = DEF_INIT
) (
  input  logic         CLK,
  input  logic         RN,
  input  logic         EN,
  input  logic [N-1:0] IN,
  output logic [N-1:0] Y,
  output logic [N-1:0] RISE,
  output logic [N-1:0] FALL
);

  for (genvar gi = 0; gi < N; gi++) begin : g_ch
    schmitt_filter_n_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .CW          (CW),
      .MAXC        (MAXC),
      .TH_HI       (TH_HI),
      .TH_LO       (TH_LO),
      .INIT        (INIT)
    ) u_ch (
      .clk  (CLK),
      .rn   (RN),
      .en   (EN),
      .din  (IN[gi]),
      .y    (Y[gi]),
      .rise (RISE[gi]),
      .fall (FALL[gi])
    );
  end

endmodule : schmitt_filter_n

// File: tb/tb_schmitt_filter_n.sv
// Directed self-checking bench for schmitt_filter_n (defaults, plus an
// INIT=1 instance sharing the same stimulus).
module tb_schmitt_filter_n;

  logic       CLK = 1'b0;
  logic       RN  = 1'b0;
  logic       EN  = 1'b1;
  logic [3:0] IN  = 4'h0;
  logic [3:0] Y, RISE, FALL;
  logic [3:0] y_i1, rise_i1, fall_i1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  schmitt_filter_n dut (
    .CLK(CLK), .RN(RN), .EN(EN), .IN(IN),
    .Y(Y), .RISE(RISE), .FALL(FALL)
  );

  schmitt_filter_n #(.INIT(1'b1)) dut_i1 (
    .CLK(CLK), .RN(RN), .EN(EN), .IN(IN),
    .Y(y_i1), .RISE(rise_i1), .FALL(fall_i1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // One clock edge, then settle to the falling edge for sampling/driving.
  task automatic edge1();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  initial begin
    logic acc;

    // 1. Reset with inputs high.
    @(negedge CLK);
    RN = 1'b0; EN = 1'b1; IN = 4'hF;
    edge1(); edge1();
    chk("rst_y",      Y,       4'h0);
    chk("rst_rise",   RISE,    4'h0);
    chk("rst_fall",   FALL,    4'h0);
    chk("rst_y_init", y_i1,    4'hF);
    chk("rst_f_init", fall_i1, 4'h0);

    // 2. Channel 0 held high from reset: rise after edge 2+12 = 14.
    RN = 1'b1; IN = 4'b0001;
    for (int e = 1; e <= 20; e++) begin
      edge1();
      if (e == 13) chk("rise_e13_y", Y, 4'h0);
      if (e == 14) begin
        chk("rise_e14_y",    Y,       4'b0001);
        chk("rise_e14_rise", RISE,    4'b0001);
        chk("rise_e14_fall", FALL,    4'h0);
        chk("init_e14_y",    y_i1,    4'b0001);
        chk("init_e14_fall", fall_i1, 4'b1110);
      end
      if (e == 15) begin
        chk("rise_e15_rise", RISE,    4'h0);
        chk("rise_e15_y",    Y,       4'b0001);
        chk("init_e15_fall", fall_i1, 4'h0);
      end
    end

    // 3. Channel 0 saturated at 15, now held low: fall after 2+(15-3) = 14,
    //    then stays at 0 (a wrap to 15 would produce a new rise).
    IN  = 4'h0;
    acc = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      edge1();
      if (e == 13) begin
        chk("fall_e13_y",    Y,    4'b0001);
        chk("fall_e13_fall", FALL, 4'h0);
      end
      if (e == 14) begin
        chk("fall_e14_y",    Y,    4'h0);
        chk("fall_e14_fall", FALL, 4'b0001);
        chk("fall_e14_rise", RISE, 4'h0);
      end
      if (e == 15) chk("fall_e15_fall", FALL, 4'h0);
      if (e > 14) acc = acc | (|Y) | (|RISE) | (|FALL);
    end
    chk("no_wrap", acc, 1'b0);

    // 4. Channel 1 toggling every cycle never crosses the band.
    acc = 1'b0;
    for (int c = 0; c < 100; c++) begin
      IN = {2'b00, c[0], 1'b0};
      edge1();
      acc = acc | Y[1] | RISE[1];
    end
    chk("toggle_quiet", acc, 1'b0);

    // 5. Channel 2 high for 8 edges (CNT=6), freeze 20 edges, resume.
    IN = 4'b0100;
    for (int e = 1; e <= 8; e++) edge1();
    EN  = 1'b0;
    acc = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      edge1();
      acc = acc | Y[2] | RISE[2];
    end
    chk("freeze_hold", acc, 1'b0);
    EN = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      edge1();
      if (e == 5) chk("resume_e5_y", Y, 4'h0);
      if (e == 6) begin
        chk("resume_e6_y",    Y,    4'b0100);
        chk("resume_e6_rise", RISE, 4'b0100);
      end
      if (e == 7) chk("resume_e7_rise", RISE, 4'h0);
    end

    // 6. All channels together, then reset mid-run.
    RN = 1'b0; IN = 4'hF;
    edge1();
    RN = 1'b1;
    for (int e = 1; e <= 17; e++) begin
      edge1();
      if (e == 13) chk("all_e13_y", Y, 4'h0);
      if (e == 14) begin
        chk("all_e14_y",    Y,    4'hF);
        chk("all_e14_rise", RISE, 4'hF);
      end
    end
    RN = 1'b0;
    edge1();
    chk("mid_rst_y",      Y,    4'h0);
    chk("mid_rst_fall",   FALL, 4'h0);
    chk("mid_rst_rise",   RISE, 4'h0);
    chk("mid_rst_y_init", y_i1, 4'hF);
    // Counter must restart from 0: rise again only after a full 14 edges.
    RN = 1'b1;
    for (int e = 1; e <= 14; e++) begin
      edge1();
      if (e == 1)  chk("post_rst_e1_rise", RISE, 4'h0);
      if (e == 13) chk("post_rst_e13_y",   Y,    4'h0);
      if (e == 14) chk("post_rst_e14_y",   Y,    4'hF);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_schmitt_filter_n
